// File: rtl/periph_spi_master_multi.sv
// SPI master transfer engine: DATA_W-bit MSB-first words, NUM_CS active-low selects, CPOL/CPHA modes, runtime divider.
// A word completes (2*DATA_W+2)*(div_in+1) cycles after start is sampled; starts arriving while busy are dropped.
module periph_spi_master_multi #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 2,
    parameter int DIV_W  = 8
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    start_in,
    input  logic                    cpol_in,
    input  logic                    cpha_in,
    input  logic [DIV_W-1:0]        div_in,
    input  logic [$clog2(NUM_CS):0] cs_sel_in,
    input  logic                    hold_cs_in,
    input  logic                    cs_release_in,
    input  logic [DATA_W-1:0]       tx_data_in,
    input  logic                    miso_in,
    output logic                    sclk_out,
    output logic                    mosi_out,
    output logic [NUM_CS-1:0]       cs_out,
    output logic                    busy_out,
    output logic                    done_pulse_out,
    output logic [DATA_W-1:0]       rx_data_out
);
    localparam int EDGE_W = $clog2(2 * DATA_W) + 1;
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_XFER, S_TAIL} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic                cpha_q, cpha_d;
    logic                hold_q, hold_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NUM_CS-1:0]   cs_q, cs_d;
    logic                finish;
    logic                leading;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        edge_d  = edge_q;
        cpha_d  = cpha_q;
        hold_d  = hold_q;
        tx_d    = tx_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cs_d    = cs_q;
        finish  = 1'b0;
        leading = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d = S_ASSERT;
                    cnt_d   = div_in;
                    div_d   = div_in;
                    edge_d  = '0;
                    cpha_d  = cpha_in;
                    hold_d  = hold_cs_in;
                    tx_d    = tx_data_in;
                    sclk_d  = cpol_in;
                    busy_d  = 1'b1;
                    if (!cpha_in) begin
                        mosi_d = tx_data_in[DATA_W-1];
                    end
                    // Fresh select mask: releases any previously held CS, out-of-range selects none.
                    for (int i = 0; i < NUM_CS; i++) begin
                        cs_d[i] = (int'(cs_sel_in) != i);
                    end
                end else if (cs_release_in) begin
                    cs_d   = '1;
                    hold_d = 1'b0;
                end
            end
            S_ASSERT: begin
                if (cnt_q == '0) begin
                    state_d = S_XFER;
                    cnt_d   = div_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_XFER: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d   = div_q;
                    sclk_d  = ~sclk_q;
                    edge_d  = edge_q + 1'b1;
                    leading = ~edge_q[0];
                    // Sample on leading edges for CPHA=0, trailing for CPHA=1; drive on the other edge.
                    if (leading ^ cpha_q) begin
                        sh_d = {sh_q[DATA_W-2:0], miso_in};
                    end else if (cpha_q) begin
                        mosi_d = tx_q[DATA_W-1];
                        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    end else if (edge_q != LAST_EDGE) begin
                        mosi_d = tx_q[DATA_W-2];
                        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    end
                    if (edge_q == LAST_EDGE) begin
                        if (div_q == '0) begin
                            finish = 1'b1;
                        end else begin
                            state_d = S_TAIL;
                            cnt_d   = div_q;
                        end
                    end
                end
            end
            S_TAIL: begin
                if (cnt_q == DIV_W'(1)) begin
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The final tail cycle is presented as IDLE with done, so busy drops alongside the pulse.
        if (finish) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            rx_d    = sh_d;
            if (!hold_q) begin
                cs_d = '1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            edge_q  <= '0;
            cpha_q  <= 1'b0;
            hold_q  <= 1'b0;
            tx_q    <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            cpha_q  <= cpha_d;
            hold_q  <= hold_d;
            tx_q    <= tx_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
        end
    end

    assign sclk_out       = sclk_q;
    assign mosi_out       = mosi_q;
    assign cs_out         = cs_q;
    assign busy_out       = busy_q;
    assign done_pulse_out = done_q;
    assign rx_data_out    = rx_q;

endmodule
